// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry elastic buffer between IF and ID.
// Holds {pc, inst} pairs in a tiny circular queue so decode back-pressure
// never reaches fetch through a combinational path. Flush drops everything.
// Optional feature macro: IFID_NOP_FILL_EN (present a NOP when no entry is valid).
module if_id_buffer #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [XLEN-1:0] i_if_pc,
    input  logic [31:0]     i_if_inst,
    output logic            o_id_valid,
    input  logic            i_id_ready,
    output logic [XLEN-1:0] o_id_pc,
    output logic [XLEN-1:0] o_id_pc4,
    output logic [31:0]     o_id_inst,
    output logic            o_id_misalign
);

    // Occupancy doubles as the state: the buffer behaviour depends only on how full it is.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [XLEN-1:0] r_pc   [2];
    logic [31:0]     r_inst [2];

    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_head_pc;
    logic [31:0]     w_head_inst;

    // Handshakes are formed from registered readiness only, so there is no
    // combinational path from i_id_ready to o_if_ready.
    assign o_if_ready  = (r_state != FULL);
    assign o_id_valid  = (r_state != EMPTY);
    assign w_push      = i_if_valid & o_if_ready;
    assign w_pop       = o_id_valid & i_id_ready;
    assign w_head_pc   = r_pc[r_rd_ptr];
    assign w_head_inst = r_inst[r_rd_ptr];

    // Head entry drives decode; the +4 wraps naturally at the top of the address space.
    assign o_id_pc       = w_head_pc;
    assign o_id_pc4      = w_head_pc + XLEN'(4);
    assign o_id_misalign = o_id_valid & (w_head_pc[1:0] != 2'b00);

`ifdef IFID_NOP_FILL_EN
    assign o_id_inst = o_id_valid ? w_head_inst : NOP_INST;
`else
    assign o_id_inst = w_head_inst;
`endif

    // Queue storage, pointers and occupancy; flush empties the queue but keeps stale storage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= EMPTY;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
        end else if (i_flush) begin
            r_state  <= EMPTY;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_pc[r_wr_ptr]   <= i_if_pc;
                r_inst[r_wr_ptr] <= i_if_inst;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case (r_state)
                EMPTY: begin
                    if (w_push) r_state <= ONE;
                end
                ONE: begin
                    if (w_push && !w_pop)      r_state <= FULL;
                    else if (!w_push && w_pop) r_state <= EMPTY;
                end
                FULL: begin
                    if (w_pop) r_state <= ONE;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Testbench for if_id_buffer: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ifValid;
    logic        ifReady;
    logic [31:0] ifPc;
    logic [31:0] ifInst;
    logic        idValid;
    logic        idReady;
    logic [31:0] idPc;
    logic [31:0] idPc4;
    logic [31:0] idInst;
    logic        idMisalign;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t model[$];

    if_id_buffer #(.XLEN(32), .NOP_INST(NOP)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_flush       (flush),
        .i_if_valid    (ifValid),
        .o_if_ready    (ifReady),
        .i_if_pc       (ifPc),
        .i_if_inst     (ifInst),
        .o_id_valid    (idValid),
        .i_id_ready    (idReady),
        .o_id_pc       (idPc),
        .o_id_pc4      (idPc4),
        .o_id_inst     (idInst),
        .o_id_misalign (idMisalign)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, clock it, and settle 1 unit after the edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl);
        ifValid = v;
        ifPc    = pc;
        ifInst  = inst;
        idReady = rdy;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifValid = 1'b0; ifPc = '0; ifInst = '0; idReady = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] expInst;
`ifdef IFID_NOP_FILL_EN
        expInst = NOP;
`else
        expInst = 32'h0;
`endif
        do_reset();
        vectors++; if (ifReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_if_ready got %b want 1", ifReady); end
        vectors++; if (idValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_valid got %b want 0", idValid); end
        vectors++; if (idPc !== 32'h0) begin errors++; $display("[TB] FAIL reset_id_pc got %h want 0", idPc); end
        vectors++; if (idPc4 !== 32'h4) begin errors++; $display("[TB] FAIL reset_id_pc4 got %h want 4", idPc4); end
        vectors++; if (idInst !== expInst) begin errors++; $display("[TB] FAIL reset_id_inst got %h want %h", idInst, expInst); end
        vectors++; if (idMisalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign got %b want 0", idMisalign); end
    endtask

    task automatic test_stream();
        logic [31:0] pcs   [3];
        logic [31:0] insts [3];
        pcs   = '{32'h0, 32'h4, 32'h8};
        insts = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        // No bypass: an offer in the current cycle is not yet visible.
        ifValid = 1'b1; ifPc = pcs[0]; ifInst = insts[0]; idReady = 1'b1; flush = 1'b0;
        #1;
        vectors++; if (idValid !== 1'b0) begin errors++; $display("[TB] FAIL stream_no_bypass got %b want 0", idValid); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pcs[i], insts[i], 1'b1, 1'b0);
            vectors++; if (idValid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid[%0d] got %b want 1", i, idValid); end
            vectors++; if (idPc !== pcs[i]) begin errors++; $display("[TB] FAIL stream_pc[%0d] got %h want %h", i, idPc, pcs[i]); end
            vectors++; if (idPc4 !== pcs[i] + 32'd4) begin errors++; $display("[TB] FAIL stream_pc4[%0d] got %h want %h", i, idPc4, pcs[i] + 32'd4); end
            vectors++; if (idInst !== insts[i]) begin errors++; $display("[TB] FAIL stream_inst[%0d] got %h want %h", i, idInst, insts[i]); end
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vectors++; if (idValid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drained got %b want 0", idValid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [4];
        pcs = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pcs[i], 32'h1000 + pcs[i], 1'b0, 1'b0);
            vectors++;
            if (ifReady !== (i == 0)) begin errors++; $display("[TB] FAIL bp_if_ready[%0d] got %b want %b", i, ifReady, (i == 0)); end
            vectors++; if (idPc !== 32'h0) begin errors++; $display("[TB] FAIL bp_head[%0d] got %h want 0", i, idPc); end
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vectors++; if (ifReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after_pop got %b want 1", ifReady); end
        vectors++; if (idPc !== 32'h4 || idValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_second got %h/%b want 00000004/1", idPc, idValid); end
        vectors++; if (idInst !== 32'h1004) begin errors++; $display("[TB] FAIL bp_second_inst got %h want 00001004", idInst); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vectors++; if (idValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup got %b want 0", idValid); end
    endtask

    task automatic test_flush();
        step(1'b1, 32'h40, 32'h0000_0033, 1'b0, 1'b0);
        step(1'b1, 32'h44, 32'h0000_0033, 1'b0, 1'b0);
        vectors++; if (ifReady !== 1'b0) begin errors++; $display("[TB] FAIL flush_full got %b want 0", ifReady); end
        // Fill state is FULL so ifReady is low; the PC 0x100 offer must vanish anyway.
        step(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b1);
        vectors++; if (idValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b want 0", idValid); end
        vectors++; if (ifReady !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got %b want 1", ifReady); end
`ifdef IFID_NOP_FILL_EN
        vectors++; if (idInst !== NOP) begin errors++; $display("[TB] FAIL flush_nop got %h want %h", idInst, NOP); end
`endif
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vectors++; if (idValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_dropped got %b want 0", idValid); end
        // Offer accepted in a cycle with ifReady high and flush asserted is also dropped.
        step(1'b1, 32'h200, 32'h1, 1'b0, 1'b1);
        vectors++; if (idValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop_offer got %b want 0", idValid); end
    endtask

    task automatic test_boundary();
        step(1'b1, 32'hFFFF_FFFC, 32'h0000_0013, 1'b1, 1'b0);
        vectors++; if (idPc4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4 got %h want 00000000", idPc4); end
        vectors++; if (idMisalign !== 1'b0) begin errors++; $display("[TB] FAIL wrap_misalign got %b want 0", idMisalign); end
        step(1'b1, 32'h0000_0006, 32'h0000_0013, 1'b1, 1'b0);
        vectors++; if (idMisalign !== 1'b1) begin errors++; $display("[TB] FAIL misalign got %b want 1", idMisalign); end
        vectors++; if (idPc4 !== 32'hA) begin errors++; $display("[TB] FAIL misalign_pc4 got %h want 0000000a", idPc4); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vectors++; if (idMisalign !== 1'b0) begin errors++; $display("[TB] FAIL misalign_empty got %b want 0", idMisalign); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'h300, 32'h5, 1'b0, 1'b0);
        step(1'b1, 32'h304, 32'h6, 1'b0, 1'b0);
        #2 rst = 1'b1; flush = 1'b1;
        #1;
        vectors++; if (idValid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid got %b want 0", idValid); end
        vectors++; if (ifReady !== 1'b1) begin errors++; $display("[TB] FAIL async_ready got %b want 1", ifReady); end
        vectors++; if (idPc !== 32'h0 || idPc4 !== 32'h4) begin errors++; $display("[TB] FAIL async_pc got %h/%h want 0/4", idPc, idPc4); end
        #1 rst = 1'b0; flush = 1'b0; ifValid = 1'b0;
        @(posedge clk);
        #1;
        vectors++; if (idValid !== 1'b0) begin errors++; $display("[TB] FAIL async_after got %b want 0", idValid); end
    endtask

    task automatic test_random();
        logic        v, rdy, fl, expReady, expValid;
        logic [31:0] pc, inst;
        entry_t      head, offer;
        model.delete();
        for (int n = 0; n < 600; n++) begin
            v    = ($urandom_range(0, 3) != 0);
            rdy  = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            pc   = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            inst = $urandom;
            expReady = (model.size() < 2);
            expValid = (model.size() > 0);
            ifValid = v; ifPc = pc; ifInst = inst; idReady = rdy; flush = fl;
            #1;
            vectors++; if (ifReady !== expReady) begin errors++; $display("[TB] FAIL rand_if_ready[%0d] got %b want %b", n, ifReady, expReady); end
            @(posedge clk);
            if (fl) begin
                model.delete();
            end else begin
                if (expValid && rdy) void'(model.pop_front());
                if (v && expReady) begin
                    offer.pc = pc; offer.inst = inst;
                    model.push_back(offer);
                end
            end
            #1;
            vectors++; if (idValid !== (model.size() > 0)) begin errors++; $display("[TB] FAIL rand_valid[%0d] got %b want %b", n, idValid, (model.size() > 0)); end
            if (model.size() > 0) begin
                head = model[0];
                vectors++; if (idPc !== head.pc) begin errors++; $display("[TB] FAIL rand_pc[%0d] got %h want %h", n, idPc, head.pc); end
                vectors++; if (idPc4 !== head.pc + 32'd4) begin errors++; $display("[TB] FAIL rand_pc4[%0d] got %h want %h", n, idPc4, head.pc + 32'd4); end
                vectors++; if (idInst !== head.inst) begin errors++; $display("[TB] FAIL rand_inst[%0d] got %h want %h", n, idInst, head.inst); end
                vectors++; if (idMisalign !== (head.pc % 4 != 0)) begin errors++; $display("[TB] FAIL rand_misalign[%0d] got %b want %b", n, idMisalign, (head.pc % 4 != 0)); end
            end else begin
                vectors++; if (idMisalign !== 1'b0) begin errors++; $display("[TB] FAIL rand_misalign_empty[%0d] got %b want 0", n, idMisalign); end
`ifdef IFID_NOP_FILL_EN
                vectors++; if (idInst !== NOP) begin errors++; $display("[TB] FAIL rand_nop[%0d] got %h want %h", n, idInst, NOP); end
`endif
            end
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_flush();
        test_boundary();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
